// File: rtl/led_chain_driver_pkg.sv
// Shared types and defaults for the cascaded LED shift-register driver.
package led_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } led_state_e;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_CLK_DIV = 2;

  // Bits per frame for a chain of n_chain devices of data_w bits each
  function automatic int unsigned led_total(input int unsigned data_w,
                                            input int unsigned n_chain);
    return data_w * n_chain;
  endfunction

endpackage

// File: rtl/led_chain_driver_clk_div.sv
// Half-period tick generator for the serial shift clock.
// tick is high for one clk cycle every CLK_DIV cycles; restart holds the
// counter at zero so the first half-period of a frame is always full length.
module led_clk_div
  import led_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and tick decode
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_chain_driver.sv
// Serial driver for cascaded 74HC595-style LED shift registers: captures a
// frame on load, shifts it out on sdo/sclk, then pulses latch. A one-deep
// pending slot holds the next frame (newest wins) while one is in flight.
module led_chain_driver
  import led_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned N_CHAIN      = 1,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned LATCH_HALVES = 2,
  localparam int unsigned TOTAL       = led_total(DATA_W, N_CHAIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TOTAL-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output logic             done
);

  localparam int unsigned BIT_W  = $clog2(TOTAL + 1);
  localparam int unsigned HALF_W = $clog2(LATCH_HALVES + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(TOTAL - 1);
  localparam logic [BIT_W-1:0]  ALL_BITS  = BIT_W'(TOTAL);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(LATCH_HALVES - 1);

  led_state_e        state_q, state_d;
  logic [TOTAL-1:0]  sr_q, sr_d;
  logic [TOTAL-1:0]  pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              latch_q, latch_d;
  logic              done_q, done_d;

  logic              tick;
  logic              div_restart;
  logic [TOTAL-1:0]  frame_sel;
  logic [TOTAL-1:0]  sr_shifted;

  // Bit presented on sdo for a given shift-register content
  function automatic logic first_bit(input logic [TOTAL-1:0] v);
    return MSB_FIRST ? v[TOTAL-1] : v[0];
  endfunction

  assign div_restart = (state_q == IDLE);

  led_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .restart(div_restart),
    .tick   (tick)
  );

  // Next-state, datapath and output decode for the frame sequencer
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    bit_cnt_d    = bit_cnt_q;
    half_cnt_d   = half_cnt_q;
    sclk_d       = sclk_q;
    sdo_d        = sdo_q;
    latch_d      = latch_q;
    done_d       = 1'b0;
    frame_sel    = pend_valid_q ? pend_q : data;
    sr_shifted   = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

    unique case (state_q)
      IDLE: begin
        sclk_d     = 1'b0;
        sdo_d      = 1'b0;
        latch_d    = 1'b0;
        bit_cnt_d  = '0;
        half_cnt_d = '0;
        // A pending frame takes priority; a load arriving the same cycle
        // refills the slot that is being emptied.
        if (pend_valid_q || load) begin
          sr_d         = frame_sel;
          sdo_d        = first_bit(frame_sel);
          state_d      = SHIFT;
          pend_valid_d = pend_valid_q && load;
          if (pend_valid_q && load) pend_d = data;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = ALL_BITS;
              latch_d   = 1'b1;
              state_d   = LATCH;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              sr_d      = sr_shifted;
              sdo_d     = first_bit(sr_shifted);
            end
          end
        end
      end

      LATCH: begin
        if (tick) begin
          if (half_cnt_q == LAST_HALF) begin
            half_cnt_d = '0;
            latch_d    = 1'b0;
            sdo_d      = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // While a frame is in flight, any load lands in the pending slot
    if (state_q != IDLE && load) begin
      pend_d       = data;
      pend_valid_d = 1'b1;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      half_cnt_q   <= '0;
      sclk_q       <= 1'b0;
      sdo_q        <= 1'b0;
      latch_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      half_cnt_q   <= half_cnt_d;
      sclk_q       <= sclk_d;
      sdo_q        <= sdo_d;
      latch_q      <= latch_d;
      done_q       <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdo   = sdo_q;
  assign latch = latch_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign ready = !pend_valid_q;

endmodule

// File: tb/tb_led_chain_driver.sv
// Scoreboard bench for led_chain_driver. Three instances:
//   0: DATA_W=16 N_CHAIN=1 CLK_DIV=2 MSB_FIRST=1
//   1: DATA_W=16 N_CHAIN=2 CLK_DIV=1 MSB_FIRST=1
//   2: DATA_W=16 N_CHAIN=1 CLK_DIV=2 MSB_FIRST=0
// Stimulus pushes the expected captured frame and absolute latch/done cycles;
// the monitor rebuilds each frame from sdo at sclk rises and checks on
// latch rise and on done.
module tb_led_chain_driver;

  typedef struct {
    int          dut;
    logic [31:0] frame;
    int          latch_cyc;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_v  [3];
  logic [15:0] d0;
  logic [31:0] d1;
  logic [15:0] d2;
  logic        ready_o [3];
  logic        busy_o  [3];
  logic        sclk_o  [3];
  logic        sdo_o   [3];
  logic        latch_o [3];
  logic        done_o  [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  exp_t sb[$];

  // Hand-computed per-instance constants: frame bits and latch-high cycles
  int total [3] = '{16, 32, 16};
  int latw  [3] = '{4, 2, 4};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  led_chain_driver #(.DATA_W(16), .N_CHAIN(1), .CLK_DIV(2), .MSB_FIRST(1'b1), .LATCH_HALVES(2)) u_dut0 (
    .clk(clk), .rst(rst), .data(d0), .load(load_v[0]), .ready(ready_o[0]), .busy(busy_o[0]),
    .sclk(sclk_o[0]), .sdo(sdo_o[0]), .latch(latch_o[0]), .done(done_o[0]));

  led_chain_driver #(.DATA_W(16), .N_CHAIN(2), .CLK_DIV(1), .MSB_FIRST(1'b1), .LATCH_HALVES(2)) u_dut1 (
    .clk(clk), .rst(rst), .data(d1), .load(load_v[1]), .ready(ready_o[1]), .busy(busy_o[1]),
    .sclk(sclk_o[1]), .sdo(sdo_o[1]), .latch(latch_o[1]), .done(done_o[1]));

  led_chain_driver #(.DATA_W(16), .N_CHAIN(1), .CLK_DIV(2), .MSB_FIRST(1'b0), .LATCH_HALVES(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(d2), .load(load_v[2]), .ready(ready_o[2]), .busy(busy_o[2]),
    .sclk(sclk_o[2]), .sdo(sdo_o[2]), .latch(latch_o[2]), .done(done_o[2]));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int find(input int i);
    foreach (sb[k]) if (sb[k].dut == i) return k;
    return -1;
  endfunction

  function automatic logic [31:0] outs(input int i);
    return 32'({sclk_o[i], sdo_o[i], latch_o[i], done_o[i], busy_o[i], ready_o[i]});
  endfunction

  // ---------------- monitor ----------------
  logic        prev_sclk  [3];
  logic        prev_latch [3];
  logic        prev_sdo   [3];
  logic [31:0] cap        [3];
  int          nbits      [3];
  int          lat_w      [3];
  int          latch_rises[3] = '{0, 0, 0};
  int          idx_m;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_sclk[i]  = 1'b0;
        prev_latch[i] = 1'b0;
        prev_sdo[i]   = 1'b0;
        cap[i]        = '0;
        nbits[i]      = 0;
        lat_w[i]      = 0;
      end else begin
        if (busy_o[i] && (sdo_o[i] !== prev_sdo[i]))
          chk("sdo_change_sclk_low", 32'(sclk_o[i]), 32'd0);
        if (sclk_o[i] && !prev_sclk[i]) begin
          cap[i] = {cap[i][30:0], sdo_o[i]};
          nbits[i]++;
        end
        if (latch_o[i]) lat_w[i]++;
        if (latch_o[i] && !prev_latch[i]) begin
          latch_rises[i]++;
          idx_m = find(i);
          if (idx_m < 0) chk("latch_unexpected", 32'd1, 32'd0);
          else begin
            chk("frame_bits", cap[i], sb[idx_m].frame);
            chk("bit_count", 32'(nbits[i]), 32'(total[i]));
            chk("latch_rise_cycle", 32'(cyc), 32'(sb[idx_m].latch_cyc));
          end
        end
        if (done_o[i]) begin
          idx_m = find(i);
          if (idx_m < 0) chk("done_unexpected", 32'd1, 32'd0);
          else begin
            chk("done_cycle", 32'(cyc), 32'(sb[idx_m].done_cyc));
            chk("latch_width", 32'(lat_w[i]), 32'(latw[i]));
            chk("busy_at_done", 32'(busy_o[i]), 32'd0);
            sb.delete(idx_m);
          end
          cap[i]   = '0;
          nbits[i] = 0;
          lat_w[i] = 0;
        end
        prev_sclk[i]  = sclk_o[i];
        prev_latch[i] = latch_o[i];
        prev_sdo[i]   = sdo_o[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    foreach (load_v[k]) load_v[k] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [31:0] d, input logic [31:0] expc,
                       input bit push, input int lat_abs, input int done_abs);
    load_v[i] = 1'b1;
    case (i)
      0:       d0 = d[15:0];
      1:       d1 = d;
      default: d2 = d[15:0];
    endcase
    if (push) sb.push_back('{i, expc, lat_abs, done_abs});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int c0;
    int lr;
    rst = 1'b1;
    foreach (load_v[k]) load_v[k] = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) chk("reset_outputs", outs(i), 32'b000001);
    rst = 1'b0;
    step();

    // Basic frames on all three configurations, loaded in the same cycle
    step();
    c0 = cyc;
    issue(0, 32'h0000A5C3, 32'h0000A5C3, 1'b1, c0 + 65, c0 + 69);
    issue(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, c0 + 65, c0 + 67);
    issue(2, 32'h00000001, 32'h00008000, 1'b1, c0 + 65, c0 + 69);
    step();
    chk("busy_after_load", 32'(busy_o[0]), 32'd1);
    chk("ready_after_load", 32'(ready_o[0]), 32'd1);
    drain();

    // Pending slot: 2222 is overwritten by 3333 before it is consumed
    step();
    c0 = cyc;
    issue(0, 32'h1111, 32'h1111, 1'b1, c0 + 65, c0 + 69);
    while (cyc < c0 + 10) step();
    chk("ready_before_pend", 32'(ready_o[0]), 32'd1);
    issue(0, 32'h2222, 32'h2222, 1'b0, 0, 0);
    step();
    chk("ready_pend_full", 32'(ready_o[0]), 32'd0);
    while (cyc < c0 + 20) step();
    issue(0, 32'h3333, 32'h3333, 1'b1, c0 + 134, c0 + 138);
    step();
    chk("ready_pend_overwrite", 32'(ready_o[0]), 32'd0);
    while (cyc < c0 + 69) step();
    chk("done_first_frame", 32'(done_o[0]), 32'd1);
    chk("ready_at_first_done", 32'(ready_o[0]), 32'd0);
    step();
    chk("busy_after_pend_start", 32'(busy_o[0]), 32'd1);
    chk("ready_after_pend_start", 32'(ready_o[0]), 32'd1);
    drain();

    // Load in the exact done cycle with the pending slot empty
    step();
    c0 = cyc;
    issue(0, 32'h0F0F, 32'h0F0F, 1'b1, c0 + 65, c0 + 69);
    while (cyc < c0 + 69) begin
      step();
      if (cyc >= c0 + 1 && cyc <= c0 + 68) begin
        chk("edge_busy", 32'(busy_o[0]), 32'd1);
        chk("edge_ready", 32'(ready_o[0]), 32'd1);
      end
    end
    chk("edge_done_cycle", outs(0), 32'b000101);
    issue(0, 32'hF00F, 32'hF00F, 1'b1, c0 + 134, c0 + 138);
    step();
    chk("edge_busy_restart", 32'(busy_o[0]), 32'd1);
    chk("edge_ready_restart", 32'(ready_o[0]), 32'd1);
    chk("edge_first_bit", 32'(sdo_o[0]), 32'd1);
    drain();

    // Reset in the middle of a shift aborts without a latch pulse
    step();
    c0 = cyc;
    lr = latch_rises[0];
    issue(0, 32'hFFFF, 32'hFFFF, 1'b0, 0, 0);
    while (cyc < c0 + 30) step();
    chk("busy_before_abort", 32'(busy_o[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", outs(0), 32'b000001);
    step();
    step();
    rst = 1'b0;
    repeat (80) step();
    chk("no_latch_after_abort", 32'(latch_rises[0]), 32'(lr));
    step();
    issue(0, 32'h1234, 32'h1234, 1'b1, cyc + 65, cyc + 69);
    drain();

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
